// File: rtl/sisc_loader_if.sv
// Byte-stream and instruction-memory write bus for the SISC boot loader.
// slave  : loader side (consumes bytes, drives memory writes).
// master : stream source / memory side.
interface sisc_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] im_addr;
   logic [31:0] im_wdata;
   logic        im_we;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output im_addr,
      output im_wdata,
      output im_we
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  im_addr,
      input  im_wdata,
      input  im_we
   );
endinterface

// File: rtl/sisc_loader.sv
// SISC boot loader: takes a 16-bit big-endian word count followed by
// big-endian 32-bit words from a byte stream, writes them to instruction
// memory from BASE_ADDR upward, then releases the core via core_run.
// Optional trailing XOR checksum byte is enabled by LOADER_CHECKSUM_EN.
// All outputs are registered; in_ready depends on the current state only.
module sisc_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] MAX_WORDS = 16'd16384
) (
   input  logic                clk,
   input  logic                rst_f,
   input  logic                load_start,
   sisc_loader_if.slave        bus,
   output logic                core_run,
   output logic                busy,
   output logic                err,
   output logic [15:0]         word_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LOAD,
      S_WRITE,
      S_RUN,
      S_ERR
`ifdef LOADER_CHECKSUM_EN
      , S_CHK
`endif
   } state_t;

   // State entered once the last word (or an empty header) is done.
`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_DONE = S_CHK;
`else
   localparam state_t S_DONE = S_RUN;
`endif

   state_t      state_q, state_d;
   logic [15:0] hdr_q, hdr_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [23:0] asm_q, asm_d;
   logic [15:0] addr_d;
   logic [31:0] wdata_d;
   logic [15:0] wcnt_d;
   logic [7:0]  xor_q, xor_d;

   logic        accept;
   logic [15:0] hdr_full;
   logic [15:0] wcnt_inc;

   assign accept   = bus.in_valid & bus.in_ready;
   assign hdr_full = {hdr_q[15:8], bus.in_data};
   assign wcnt_inc = word_cnt + 16'd1;

   // Next-state and next-register computation.
   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      bcnt_d  = bcnt_q;
      asm_d   = asm_q;
      addr_d  = bus.im_addr;
      wdata_d = bus.im_wdata;
      wcnt_d  = word_cnt;
      xor_d   = xor_q;

      case (state_q)
         S_IDLE: begin
            bcnt_d = '0;
            xor_d  = '0;
            if (load_start) begin
               state_d = S_HDR;
            end
         end

         S_HDR: begin
            if (accept) begin
               xor_d = xor_q ^ bus.in_data;
               if (bcnt_q == 2'd0) begin
                  hdr_d[15:8] = bus.in_data;
                  bcnt_d      = 2'd1;
               end else begin
                  hdr_d  = hdr_full;
                  bcnt_d = '0;
                  if (hdr_full == 16'd0) begin
                     state_d = S_DONE;
                  end else if (hdr_full > MAX_WORDS) begin
                     state_d = S_ERR;
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end
         end

         S_LOAD: begin
            if (accept) begin
               xor_d = xor_q ^ bus.in_data;
               if (bcnt_q == 2'd3) begin
                  // Address is latched here so im_addr is already valid
                  // during the single WRITE cycle.
                  wdata_d = {asm_q, bus.in_data};
                  addr_d  = BASE_ADDR + word_cnt;
                  bcnt_d  = '0;
                  state_d = S_WRITE;
               end else begin
                  asm_d  = {asm_q[15:0], bus.in_data};
                  bcnt_d = bcnt_q + 2'd1;
               end
            end
         end

         S_WRITE: begin
            wcnt_d = wcnt_inc;
            if (wcnt_inc == hdr_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_LOAD;
            end
         end

`ifdef LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               if (bus.in_data == xor_q) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
`endif

         S_RUN: state_d = S_RUN;

         S_ERR: state_d = S_ERR;

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; outputs are decoded from the next state
   // so that they are registered yet track the state they belong to.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         state_q      <= S_IDLE;
         hdr_q        <= '0;
         bcnt_q       <= '0;
         asm_q        <= '0;
         xor_q        <= '0;
         bus.im_addr  <= BASE_ADDR;
         bus.im_wdata <= '0;
         bus.im_we    <= 1'b0;
         bus.in_ready <= 1'b0;
         word_cnt     <= '0;
         core_run     <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         bcnt_q       <= bcnt_d;
         asm_q        <= asm_d;
         xor_q        <= xor_d;
         bus.im_addr  <= addr_d;
         bus.im_wdata <= wdata_d;
         word_cnt     <= wcnt_d;
         bus.im_we    <= (state_d == S_WRITE);
`ifdef LOADER_CHECKSUM_EN
         bus.in_ready <= (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CHK);
         busy         <= (state_d == S_HDR) || (state_d == S_LOAD) ||
                         (state_d == S_WRITE) || (state_d == S_CHK);
`else
         bus.in_ready <= (state_d == S_HDR) || (state_d == S_LOAD);
         busy         <= (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_WRITE);
`endif
         core_run     <= (state_d == S_RUN);
         err          <= (state_d == S_ERR);
      end
   end

endmodule
